// File: rtl/uart_frame_parser.sv
// uart_frame_parser: extracts SYNC, LEN, PAYLOAD[LEN], CSUM frames from a
// received-byte strobe stream, validates length and checksum, buffers the
// payload and replays it on a valid/ready stream. Bad frames raise frame_err
// with a cause code.
module uart_frame_parser #(
    parameter int          MAX_LEN     = 16,
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
    parameter int          TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [1:0] err_code,
    output logic       busy
);

    localparam int         AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int         TW        = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [8:0] MAX_LEN_V = 9'(MAX_LEN);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    localparam logic [1:0] ERR_OVERRUN = 2'd0;
    localparam logic [1:0] ERR_LENGTH  = 2'd1;
    localparam logic [1:0] ERR_CSUM    = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    typedef enum logic [2:0] {
        S_HUNT,
        S_LEN,
        S_PAYLOAD,
        S_CSUM,
        S_DRAIN
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      len_q, len_d;
    logic [7:0]      idx_q, idx_d;
    logic [7:0]      acc_q, acc_d;
    logic [7:0]      rd_idx_q, rd_idx_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [7:0]      out_data_q, out_data_d;
    logic            out_valid_q, out_valid_d;
    logic            out_last_q, out_last_d;
    logic            frame_ok_q, frame_ok_d;
    logic            frame_err_q, frame_err_d;
    logic [1:0]      err_code_q, err_code_d;
    logic            busy_q, busy_d;

    // Payload buffer: no reset so it maps onto plain RAM; pointers gate validity.
    logic [7:0]      mem [MAX_LEN];
    logic            wr_en;
    logic [7:0]      rd_next;
    logic [7:0]      len_m1;
    logic [7:0]      idx_next;

    assign rd_next  = rd_idx_q + 8'd1;
    assign len_m1   = len_q - 8'd1;
    assign idx_next = idx_q + 8'd1;

    // Buffer write port: one payload byte per accepted strobe.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[idx_q[AW-1:0]] <= in_data;
        end
    end

    // Parser state, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_HUNT;
            len_q       <= '0;
            idx_q       <= '0;
            acc_q       <= '0;
            rd_idx_q    <= '0;
            tmo_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            err_code_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            rd_idx_q    <= rd_idx_d;
            tmo_q       <= tmo_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            frame_ok_q  <= frame_ok_d;
            frame_err_q <= frame_err_d;
            err_code_q  <= err_code_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state logic: frame decoding, timeout supervision and drain sequencing.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        rd_idx_d    = rd_idx_q;
        tmo_d       = tmo_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        frame_ok_d  = 1'b0;
        frame_err_d = 1'b0;
        err_code_d  = err_code_q;
        wr_en       = 1'b0;

        case (state_q)
            S_HUNT: begin
                if (in_valid && (in_data == SYNC_BYTE)) begin
                    state_d = S_LEN;
                    tmo_d   = '0;
                end
            end

            S_LEN, S_PAYLOAD, S_CSUM: begin
                if (in_valid) begin
                    // A byte always beats an expiring timeout.
                    tmo_d = '0;
                    if (state_q == S_LEN) begin
                        if ((in_data != 8'd0) && ({1'b0, in_data} <= MAX_LEN_V)) begin
                            len_d   = in_data;
                            acc_d   = in_data;
                            idx_d   = '0;
                            state_d = S_PAYLOAD;
                        end else begin
                            frame_err_d = 1'b1;
                            err_code_d  = ERR_LENGTH;
                            state_d     = S_HUNT;
                        end
                    end else if (state_q == S_PAYLOAD) begin
                        wr_en = 1'b1;
                        acc_d = acc_q + in_data;
                        idx_d = idx_next;
                        if (idx_next == len_q) begin
                            state_d = S_CSUM;
                        end
                    end else begin
                        if (8'(acc_q + in_data) == 8'd0) begin
                            frame_ok_d  = 1'b1;
                            rd_idx_d    = '0;
                            out_data_d  = mem[{AW{1'b0}}];
                            out_valid_d = 1'b1;
                            out_last_d  = (len_q == 8'd1);
                            state_d     = S_DRAIN;
                        end else begin
                            frame_err_d = 1'b1;
                            err_code_d  = ERR_CSUM;
                            state_d     = S_HUNT;
                        end
                    end
                end else if (tmo_q == TMO_LAST) begin
                    frame_err_d = 1'b1;
                    err_code_d  = ERR_TIMEOUT;
                    state_d     = S_HUNT;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end

            S_DRAIN: begin
                // No room to accept a new frame while the buffer is replayed.
                if (in_valid) begin
                    frame_err_d = 1'b1;
                    err_code_d  = ERR_OVERRUN;
                end
                if (out_valid_q && out_ready) begin
                    if (rd_idx_q == len_m1) begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        state_d     = S_HUNT;
                    end else begin
                        rd_idx_d   = rd_next;
                        out_data_d = mem[rd_next[AW-1:0]];
                        out_last_d = (rd_next == len_m1);
                    end
                end
            end

            default: begin
                state_d = S_HUNT;
            end
        endcase

        busy_d = (state_d != S_HUNT);
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign frame_ok  = frame_ok_q;
    assign frame_err = frame_err_q;
    assign err_code  = err_code_q;
    assign busy      = busy_q;

endmodule
